mem_snoop_multi: RTL and testbench

Multi-channel memory-write snoop and cycle-count register bank for the RISC-V test system. It is the parametrised successor to the single end-sequence detector.
- Watches the core's data-memory write port passively.
- Matches up to NUM_CH programmable address/data/mask triplets.
- Timestamps each hit relative to the rising edge of fetch_enable.
- Exposes status, counts and configuration through a simple word-addressed register port behind the PS AXI bridge, at base 0x4000_9000.

---
 rtl/mem_snoop_multi.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_mem_snoop_multi.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_snoop_multi.sv
// mem_snoop_multi: multi-channel data-memory write snoop with cycle timestamps.
// Passively watches the core's data write port. It matches up to NUM_CH
// address/data/mask triplets and timestamps each first hit relative to the
// start of the run. State, counts and configuration are exposed through a
// word-addressed register port.
// Optional feature macro: SNOOP_TIMEOUT_EN adds the TIMEOUT register (0x0C)
// and the TIMEOUT state. When it is undefined, 0x0C reads 0 and ignores writes.

module mem_snoop_multi #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_enable,
    input  logic              data_req,
    input  logic              data_gnt,
    input  logic              data_we,
    input  logic [3:0]        data_be,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [31:0]       data_wdata,
    input  logic              reg_we,
    input  logic              reg_re,
    input  logic [7:0]        reg_addr,
    input  logic [31:0]       reg_wdata,
    output logic [31:0]       reg_rdata,
    output logic              reg_rvalid,
    output logic              end_detected,
    output logic              irq
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_DONE    = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

    localparam logic [5:0] W_STATUS  = 6'h00;
    localparam logic [5:0] W_END     = 6'h01;
    localparam logic [5:0] W_CTRL    = 6'h02;
    localparam logic [5:0] W_TIMEOUT = 6'h03;
    localparam logic [5:0] W_CYCLES  = 6'h04;
    localparam logic [3:0] NUM_CH_L  = 4'(NUM_CH);

    state_t            state;
    logic              fe_q;
    logic [CNT_W-1:0]  cycles;
    logic [CNT_W-1:0]  end_cycles;
    logic [NUM_CH-1:0] hit;
    logic [NUM_CH-1:0] en;
    logic              mode;
    logic [31:0]       addr_r [NUM_CH];
    logic [31:0]       data_r [NUM_CH];
    logic [31:0]       mask_r [NUM_CH];
    logic [CNT_W-1:0]  cap_r  [NUM_CH];
    logic [3:0]        byte_used [NUM_CH];
`ifdef SNOOP_TIMEOUT_EN
    logic [31:0]       timeout_val;
`endif

    logic [NUM_CH-1:0] match;
    logic [NUM_CH-1:0] new_hit;
    logic [NUM_CH-1:0] hit_next;
    logic              accepted;
    logic              complete;
    logic              tmo_hit;
    logic              fe_rise;
    logic              clear_req;
    logic [5:0]        word;
    logic [3:0]        ch_num;
    logic [1:0]        sub;
    logic              ch_valid;
    logic [31:0]       status_w;
    logic [31:0]       ctrl_w;
    logic [31:0]       rd_mux;
    logic              unused_bits;

    // Byte-address low bits carry no information for word-granular matching/decoding.
    assign unused_bits = ^{reg_addr[1:0], data_addr[1:0]};

    // Register decode: fixed words below 0x20, then four words per channel.
    always_comb begin
        word      = reg_addr[7:2];
        ch_num    = word[5:2] - 4'd2;
        sub       = word[1:0];
        ch_valid  = (word >= 6'd8) && (word < 6'd40) && (ch_num < NUM_CH_L);
        clear_req = reg_we && (word == W_CTRL) && reg_wdata[31];
        fe_rise   = fetch_enable && !fe_q;
    end

    // Per-channel compare of the snooped write against its address/data/mask triplet.
    always_comb begin
        accepted = data_req && data_gnt && data_we;
        for (int i = 0; i < NUM_CH; i++) begin
            for (int b = 0; b < 4; b++) begin
                byte_used[i][b] = |mask_r[i][8*b +: 8];
            end
            match[i] = accepted
                    && (data_addr[ADDR_W-1:2] == addr_r[i][ADDR_W-1:2])
                    && (((data_wdata ^ data_r[i]) & mask_r[i]) == 32'd0)
                    && ((byte_used[i] & ~data_be) == 4'd0);
        end
        new_hit  = match & en & ~hit & {NUM_CH{state == ST_RUN}};
        hit_next = hit | new_hit;
    end

    // Completion (ANY/ALL over enabled channels, including this cycle's hits) and timeout.
    always_comb begin
        complete = 1'b0;
        if (state == ST_RUN && en != '0) begin
            if (mode) begin
                complete = ((hit_next & en) == en);
            end else begin
                complete = |(hit_next & en);
            end
        end
`ifdef SNOOP_TIMEOUT_EN
        tmo_hit = (state == ST_RUN) && (timeout_val != 32'd0)
               && (32'(cycles) == (timeout_val - 32'd1));
`else
        tmo_hit = 1'b0;
`endif
    end

    // Configuration registers written through the register port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en   <= NUM_CH'(1);
            mode <= 1'b0;
`ifdef SNOOP_TIMEOUT_EN
            timeout_val <= 32'd0;
`endif
            for (int i = 0; i < NUM_CH; i++) begin
                if (i == 0) begin
                    addr_r[i] <= 32'h0010_2000;
                    data_r[i] <= 32'hDEAD_BEEF;
                    mask_r[i] <= 32'hFFFF_FFFF;
                end else begin
                    addr_r[i] <= 32'd0;
                    data_r[i] <= 32'd0;
                    mask_r[i] <= 32'd0;
                end
            end
        end else if (reg_we) begin
            if (word == W_CTRL) begin
                en   <= reg_wdata[NUM_CH-1:0];
                mode <= reg_wdata[16];
            end
`ifdef SNOOP_TIMEOUT_EN
            if (word == W_TIMEOUT) begin
                timeout_val <= reg_wdata;
            end
`endif
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_valid && ch_num == 4'(i)) begin
                    case (sub)
                        2'd0:    addr_r[i] <= reg_wdata;
                        2'd1:    data_r[i] <= reg_wdata;
                        2'd2:    mask_r[i] <= reg_wdata;
                        default: ;
                    endcase
                end
            end
        end
    end

    // Run-control FSM with cycle counter, hit capture and registered end/irq outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            fe_q         <= 1'b0;
            cycles       <= '0;
            end_cycles   <= '0;
            hit          <= '0;
            end_detected <= 1'b0;
            irq          <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                cap_r[i] <= '0;
            end
        end else begin
            fe_q <= fetch_enable;
            irq  <= 1'b0;
            if (clear_req) begin
                state        <= ST_IDLE;
                cycles       <= '0;
                end_cycles   <= '0;
                hit          <= '0;
                end_detected <= 1'b0;
                for (int i = 0; i < NUM_CH; i++) begin
                    cap_r[i] <= '0;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (fe_rise) begin
                            state      <= ST_RUN;
                            cycles     <= '0;
                            end_cycles <= '0;
                            hit        <= '0;
                            for (int i = 0; i < NUM_CH; i++) begin
                                cap_r[i] <= '0;
                            end
                        end
                    end
                    ST_RUN: begin
                        hit <= hit_next;
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (new_hit[i]) begin
                                cap_r[i] <= cycles;
                            end
                        end
                        if (complete) begin
                            state        <= ST_DONE;
                            end_cycles   <= cycles;
                            end_detected <= 1'b1;
                            irq          <= 1'b1;
                        end else if (tmo_hit) begin
                            state <= ST_TIMEOUT;
                            irq   <= 1'b1;
                        end else if (!fetch_enable) begin
                            state <= ST_IDLE;
                        end else if (cycles != '1) begin
                            cycles <= cycles + CNT_W'(1);
                        end
                    end
                    ST_DONE, ST_TIMEOUT: ;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Read mux over status, counters, configuration and per-channel registers.
    always_comb begin
        status_w        = 32'd0;
        status_w[NUM_CH-1:0] = hit;
        status_w[16]    = (state == ST_DONE);
        status_w[17]    = (state == ST_TIMEOUT);
        status_w[19:18] = state;
        ctrl_w          = 32'd0;
        ctrl_w[NUM_CH-1:0] = en;
        ctrl_w[16]      = mode;
        rd_mux          = 32'd0;
        case (word)
            W_STATUS:  rd_mux = status_w;
            W_END:     rd_mux = 32'(end_cycles);
            W_CTRL:    rd_mux = ctrl_w;
`ifdef SNOOP_TIMEOUT_EN
            W_TIMEOUT: rd_mux = timeout_val;
`else
            W_TIMEOUT: rd_mux = 32'd0;
`endif
            W_CYCLES:  rd_mux = 32'(cycles);
            default: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (ch_valid && ch_num == 4'(i)) begin
                        case (sub)
                            2'd0:    rd_mux = addr_r[i];
                            2'd1:    rd_mux = data_r[i];
                            2'd2:    rd_mux = mask_r[i];
                            default: rd_mux = 32'(cap_r[i]);
                        endcase
                    end
                end
            end
        endcase
    end

    // Read data is registered one cycle after the strobe, sampling pre-write values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_rdata  <= 32'd0;
            reg_rvalid <= 1'b0;
        end else begin
            reg_rvalid <= reg_re;
            reg_rdata  <= reg_re ? rd_mux : 32'd0;
        end
    end

endmodule

// File: tb/tb_mem_snoop_multi.sv
// tb_mem_snoop_multi: self-checking bench for mem_snoop_multi.
// Register reads push their expected value into a scoreboard queue; a monitor
// pops and compares whenever reg_rvalid is seen. Reset defaults come from a
// vector table, and the run/hit/clear corner cases are hand-written sequences
// that count RUN cycles from the first RUN cycle (CYCLES = 0).

module tb_mem_snoop_multi;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_enable = 1'b0;
    logic        data_req = 1'b0;
    logic        data_gnt = 1'b0;
    logic        data_we = 1'b0;
    logic [3:0]  data_be = 4'd0;
    logic [31:0] data_addr = 32'd0;
    logic [31:0] data_wdata = 32'd0;
    logic        reg_we = 1'b0;
    logic        reg_re = 1'b0;
    logic [7:0]  reg_addr = 8'd0;
    logic [31:0] reg_wdata = 32'd0;
    logic [31:0] reg_rdata;
    logic        reg_rvalid;
    logic        end_detected;
    logic        irq;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [31:0] value;
    } sb_t;

    typedef struct {
        string       name;
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
    } vec_t;

    sb_t  sb_q [$];
    vec_t vecs [$];
    sb_t  mon_e;

    mem_snoop_multi dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fetch_enable (fetch_enable),
        .data_req     (data_req),
        .data_gnt     (data_gnt),
        .data_we      (data_we),
        .data_be      (data_be),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .reg_we       (reg_we),
        .reg_re       (reg_re),
        .reg_addr     (reg_addr),
        .reg_wdata    (reg_wdata),
        .reg_rdata    (reg_rdata),
        .reg_rvalid   (reg_rvalid),
        .end_detected (end_detected),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
        end
    endtask

    // Scoreboard side: every read response is compared against the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n && reg_rvalid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_rvalid: got rdata 0x%08h, want no response", reg_rdata);
            end else begin
                mon_e = sb_q.pop_front();
                checkOutput(mon_e.name, reg_rdata, mon_e.value);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic readReg(input string name, input logic [7:0] addr, input logic [31:0] exp_data);
        sb_t e;
        e.name  = name;
        e.value = exp_data;
        sb_q.push_back(e);
        reg_re   = 1'b1;
        reg_addr = addr;
        tick(1);
        reg_re   = 1'b0;
    endtask

    task automatic writeReg(input logic [7:0] addr, input logic [31:0] data);
        reg_we    = 1'b1;
        reg_addr  = addr;
        reg_wdata = data;
        tick(1);
        reg_we    = 1'b0;
    endtask

    task automatic busWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        data_req   = 1'b1;
        data_gnt   = 1'b1;
        data_we    = 1'b1;
        data_addr  = addr;
        data_wdata = data;
        data_be    = be;
        tick(1);
        data_req   = 1'b0;
        data_gnt   = 1'b0;
        data_we    = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        if (v.we) begin
            writeReg(v.addr, v.wdata);
        end else begin
            readReg(v.name, v.addr, v.exp_data);
        end
    endtask

    task automatic addVec(input string name, input logic we, input logic [7:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_data);
        vec_t v;
        v.name     = name;
        v.we       = we;
        v.addr     = addr;
        v.wdata    = wdata;
        v.exp_data = exp_data;
        vecs.push_back(v);
    endtask

    // First RUN cycle (CYCLES = 0) starts right after this returns.
    task automatic startRun();
        fetch_enable = 1'b1;
        tick(1);
    endtask

    task automatic stopRun();
        fetch_enable = 1'b0;
        tick(1);
    endtask

    initial begin
        addVec("wr_unmapped",  1'b1, 8'h14, 32'hFFFF_FFFF, 32'd0);
        addVec("wr_ch4",       1'b1, 8'h60, 32'hFFFF_FFFF, 32'd0);
        addVec("wr_status",    1'b1, 8'h00, 32'hFFFF_FFFF, 32'd0);
        addVec("wr_cap0",      1'b1, 8'h2C, 32'h1234_5678, 32'd0);
        addVec("rst_status",   1'b0, 8'h00, 32'd0, 32'h0000_0000);
        addVec("rst_end",      1'b0, 8'h04, 32'd0, 32'h0000_0000);
        addVec("rst_ctrl",     1'b0, 8'h08, 32'd0, 32'h0000_0001);
        addVec("rst_timeout",  1'b0, 8'h0C, 32'd0, 32'h0000_0000);
        addVec("rst_cycles",   1'b0, 8'h10, 32'd0, 32'h0000_0000);
        addVec("rst_addr0",    1'b0, 8'h20, 32'd0, 32'h0010_2000);
        addVec("rst_data0",    1'b0, 8'h24, 32'd0, 32'hDEAD_BEEF);
        addVec("rst_mask0",    1'b0, 8'h28, 32'd0, 32'hFFFF_FFFF);
        addVec("rst_cap0",     1'b0, 8'h2C, 32'd0, 32'h0000_0000);
        addVec("rst_addr1",    1'b0, 8'h30, 32'd0, 32'h0000_0000);
        addVec("rst_mask3",    1'b0, 8'h58, 32'd0, 32'h0000_0000);
        addVec("rd_ch4",       1'b0, 8'h60, 32'd0, 32'h0000_0000);
        addVec("rd_unmapped",  1'b0, 8'h14, 32'd0, 32'h0000_0000);

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("rst_rvalid", 32'(reg_rvalid), 32'd0);
        checkOutput("rst_rdata", reg_rdata, 32'd0);
        checkOutput("rst_irq", 32'(irq), 32'd0);
        checkOutput("rst_end_detected", 32'(end_detected), 32'd0);
        tick(1);

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Default channel 0: hit in RUN cycle 100 ends the run.
        startRun();
        tick(100);
        busWrite(32'h0010_2000, 32'hDEAD_BEEF, 4'hF);
        checkOutput("def_irq_pulse", 32'(irq), 32'd1);
        checkOutput("def_end_det", 32'(end_detected), 32'd1);
        tick(1);
        checkOutput("def_irq_low", 32'(irq), 32'd0);
        checkOutput("def_end_det_held", 32'(end_detected), 32'd1);
        fetch_enable = 1'b0;
        tick(1);
        fetch_enable = 1'b1;
        tick(1);
        readReg("def_status", 8'h00, 32'h0009_0001);
        readReg("def_end", 8'h04, 32'd100);
        readReg("def_cap0", 8'h2C, 32'd100);
        writeReg(8'h08, 32'h8000_0001);
        checkOutput("clr_end_det", 32'(end_detected), 32'd0);
        readReg("clr_status", 8'h00, 32'd0);
        readReg("clr_end", 8'h04, 32'd0);
        readReg("clr_cap0", 8'h2C, 32'd0);
        readReg("clr_ctrl", 8'h08, 32'h0000_0001);
        stopRun();

        // Masked channel 1 with byte-enable coverage.
        writeReg(8'h30, 32'h0000_1000);
        writeReg(8'h34, 32'h0000_BEEF);
        writeReg(8'h38, 32'h0000_FFFF);
        writeReg(8'h08, 32'h0000_0002);
        startRun();
        busWrite(32'h0000_1000, 32'h1234_BEEF, 4'h1);
        readReg("mask_be1_status", 8'h00, 32'h0004_0000);
        busWrite(32'h0000_1000, 32'h1234_BEEE, 4'h3);
        readReg("mask_data_status", 8'h00, 32'h0004_0000);
        busWrite(32'h0000_1000, 32'h1234_BEEF, 4'h3);
        checkOutput("mask_irq", 32'(irq), 32'd1);
        readReg("mask_status", 8'h00, 32'h0009_0002);
        readReg("mask_cap1", 8'h3C, 32'd4);
        readReg("mask_end", 8'h04, 32'd4);
        writeReg(8'h08, 32'h8001_0003);
        readReg("all_ctrl", 8'h08, 32'h0001_0003);
        stopRun();

        // Mode ALL: ch0 at cycle 10 (repeat at 20 ignored), ch1 at cycle 50.
        startRun();
        tick(10);
        busWrite(32'h0010_2000, 32'hDEAD_BEEF, 4'hF);
        readReg("all_mid_status", 8'h00, 32'h0004_0001);
        tick(8);
        busWrite(32'h0010_2000, 32'hDEAD_BEEF, 4'hF);
        tick(29);
        busWrite(32'h0000_1000, 32'h0000_BEEF, 4'h3);
        checkOutput("all_irq", 32'(irq), 32'd1);
        readReg("all_cap0", 8'h2C, 32'd10);
        readReg("all_cap1", 8'h3C, 32'd50);
        readReg("all_end", 8'h04, 32'd50);
        readReg("all_status", 8'h00, 32'h0009_0003);
        writeReg(8'h08, 32'h8000_0001);
        stopRun();

        // Clear coincident with a matching write: clear wins.
        startRun();
        tick(5);
        data_req = 1'b1; data_gnt = 1'b1; data_we = 1'b1;
        data_addr = 32'h0010_2000; data_wdata = 32'hDEAD_BEEF; data_be = 4'hF;
        reg_we = 1'b1; reg_addr = 8'h08; reg_wdata = 32'h8000_0001;
        tick(1);
        data_req = 1'b0; data_gnt = 1'b0; data_we = 1'b0; reg_we = 1'b0;
        checkOutput("race_irq", 32'(irq), 32'd0);
        checkOutput("race_end_det", 32'(end_detected), 32'd0);
        readReg("race_status", 8'h00, 32'd0);
        readReg("race_cycles", 8'h10, 32'd0);
        stopRun();
        startRun();
        tick(7);
        readReg("rerun_cycles", 8'h10, 32'd7);
        stopRun();

        // fetch_enable rising together with clear: the edge is consumed.
        fetch_enable = 1'b1;
        writeReg(8'h08, 32'h8000_0001);
        tick(3);
        readReg("fe_clear_status", 8'h00, 32'd0);
        stopRun();

        // fetch_enable falls at CYCLES = 30; a new run clears hits and counter.
        writeReg(8'h08, 32'h0001_0003);
        startRun();
        tick(3);
        busWrite(32'h0010_2000, 32'hDEAD_BEEF, 4'hF);
        tick(26);
        fetch_enable = 1'b0;
        tick(1);
        readReg("fall_cycles", 8'h10, 32'd30);
        readReg("fall_status", 8'h00, 32'h0000_0001);
        readReg("fall_cap0", 8'h2C, 32'd3);
        startRun();
        readReg("restart_status", 8'h00, 32'h0004_0000);
        readReg("restart_cycles", 8'h10, 32'd1);
        readReg("restart_cap0", 8'h2C, 32'd0);
        stopRun();

        // Read and write of CTRL in the same cycle returns the old value.
        begin
            sb_t e;
            e.name  = "rw_same_ctrl";
            e.value = 32'h0001_0003;
            sb_q.push_back(e);
        end
        reg_re = 1'b1; reg_we = 1'b1; reg_addr = 8'h08; reg_wdata = 32'h0000_0001;
        tick(1);
        reg_re = 1'b0; reg_we = 1'b0;
        readReg("rw_after_ctrl", 8'h08, 32'h0000_0001);

        // Two channels hitting in the same cycle capture the same k.
        writeReg(8'h40, 32'h0010_2000);
        writeReg(8'h44, 32'hDEAD_BEEF);
        writeReg(8'h48, 32'hFFFF_FFFF);
        writeReg(8'h08, 32'h0001_0005);
        startRun();
        tick(6);
        busWrite(32'h0010_2000, 32'hDEAD_BEEF, 4'hF);
        checkOutput("multi_irq", 32'(irq), 32'd1);
        readReg("multi_cap0", 8'h2C, 32'd6);
        readReg("multi_cap2", 8'h4C, 32'd6);
        readReg("multi_status", 8'h00, 32'h0009_0005);
        readReg("multi_end", 8'h04, 32'd6);
        writeReg(8'h08, 32'h8000_0001);
        stopRun();

`ifdef SNOOP_TIMEOUT_EN
        // Timeout after 200 RUN cycles, then completion beating timeout.
        writeReg(8'h0C, 32'd200);
        readReg("tmo_reg", 8'h0C, 32'd200);
        startRun();
        tick(199);
        checkOutput("tmo_irq_before", 32'(irq), 32'd0);
        tick(1);
        checkOutput("tmo_irq", 32'(irq), 32'd1);
        checkOutput("tmo_end_det", 32'(end_detected), 32'd0);
        readReg("tmo_status", 8'h00, 32'h000E_0000);
        writeReg(8'h08, 32'h8000_0001);
        stopRun();
        writeReg(8'h0C, 32'd10);
        startRun();
        tick(9);
        busWrite(32'h0010_2000, 32'hDEAD_BEEF, 4'hF);
        readReg("tmo_race_status", 8'h00, 32'h0009_0001);
        readReg("tmo_race_end", 8'h04, 32'd9);
        writeReg(8'h08, 32'h8000_0001);
        stopRun();
`else
        // Without the timeout feature the register is inert and RUN persists.
        writeReg(8'h0C, 32'd200);
        readReg("notmo_reg", 8'h0C, 32'd0);
        startRun();
        tick(250);
        readReg("notmo_status", 8'h00, 32'h0004_0000);
        stopRun();
`endif

        tick(3);
        checkOutput("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
